// File: rtl/weight_update_scheduler_pkg.sv
// Shared types and width helpers for the weight update scheduler.
// Defaults below describe the standard 5x5, 16-bit configuration.
package weight_update_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_RD,
        ST_OFFER,
        ST_WAIT_RES,
        ST_WRITE,
        ST_DONE
    } state_t;

    localparam int NEURON_NUM_DEF        = 5;
    localparam int WEIGHT_CELL_WIDTH_DEF = 16;
    localparam int MATRIX_WIDTH          = NEURON_NUM_DEF * NEURON_NUM_DEF * WEIGHT_CELL_WIDTH_DEF;

    function automatic int matrix_width(input int neurons, input int cell_width);
        return neurons * neurons * cell_width;
    endfunction

    // A disabled timeout still needs a 1-bit counter so the port-free logic stays legal.
    function automatic int timeout_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/weight_update_scheduler_request_skid.sv
// One-deep pending request slot: holds a layer index until the scheduler pops it.
// Push and pop in the same cycle replaces the held entry.
module weight_update_scheduler_request_skid #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_push_data,
    input  logic         i_pop,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_push) begin
            r_valid <= 1'b1;
            r_data  <= i_push_data;
        end else if (i_pop) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/weight_update_scheduler.sv
// Serialises read / offer / collect / write-back of one layer's weight matrix
// around the weight updater's w and result handshakes.
//
//   state       | meaning
//   ------------+------------------------------------------------
//   ST_IDLE     | no update in flight, waiting for a request
//   ST_READ     | memory read strobe for cur_layer
//   ST_WAIT_RD  | capture read data into w
//   ST_OFFER    | w_valid high until the updater takes w
//   ST_WAIT_RES | result_ready high, timeout counter running
//   ST_WRITE    | write updated matrix back to cur_layer
//   ST_DONE     | completion pulse with error/timeout flags
module weight_update_scheduler
    import weight_update_scheduler_pkg::*;
#(
    parameter int NEURON_NUM        = 5,
    parameter int WEIGHT_CELL_WIDTH = 16,
    parameter int LAYER_ADDR_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [LAYER_ADDR_WIDTH-1:0]                         req_layer,
    input  logic                                                req_valid,
    output logic                                                req_ready,
    output logic                                                mem_rd_en,
    output logic [LAYER_ADDR_WIDTH-1:0]                         mem_rd_addr,
    input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  mem_rd_data,
    output logic                                                mem_wr_en,
    output logic [LAYER_ADDR_WIDTH-1:0]                         mem_wr_addr,
    output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  mem_wr_data,
    output logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  w,
    output logic                                                w_valid,
    input  logic                                                w_ready,
    input  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]  result,
    input  logic                                                result_valid,
    output logic                                                result_ready,
    input  logic                                                upd_error,
    output logic                                                busy,
    output logic                                                done,
    output logic                                                done_error,
    output logic                                                done_timeout
);

    localparam int MW = matrix_width(NEURON_NUM, WEIGHT_CELL_WIDTH);
    localparam int CW = timeout_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                      r_state;
    state_t                      w_next;
    logic [LAYER_ADDR_WIDTH-1:0] r_cur_layer;
    logic [MW-1:0]               r_w;
    logic [MW-1:0]               r_wr_data;
    logic [CW-1:0]               r_cnt;
    logic                        r_err;
    logic                        r_to;

    logic                        w_req_acc;
    logic                        w_slot_valid;
    logic [LAYER_ADDR_WIDTH-1:0] w_slot_layer;
    logic                        w_start_point;
    logic                        w_start;
    logic [LAYER_ADDR_WIDTH-1:0] w_start_layer;
    logic                        w_pop;
    logic                        w_push;
    logic                        w_to_hit;

    assign req_ready     = !w_slot_valid;
    assign w_req_acc     = req_valid && req_ready;
    assign w_start_point = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign w_start       = w_start_point && (w_slot_valid || w_req_acc);
    assign w_start_layer = w_slot_valid ? w_slot_layer : req_layer;
    assign w_pop         = w_start_point && w_slot_valid;
    // A request arriving at a start point with an empty slot bypasses it.
    assign w_push        = w_req_acc && !(w_start_point && !w_slot_valid);
    assign w_to_hit      = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    weight_update_scheduler_request_skid #(
        .W (LAYER_ADDR_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (req_layer),
        .i_pop       (w_pop),
        .o_valid     (w_slot_valid),
        .o_data      (w_slot_layer)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        mem_rd_en    = 1'b0;
        mem_wr_en    = 1'b0;
        w_valid      = 1'b0;
        result_ready = 1'b0;
        done         = 1'b0;
        done_error   = 1'b0;
        done_timeout = 1'b0;
        case (r_state)
            ST_IDLE:     if (w_start) w_next = ST_READ;
            ST_READ: begin
                mem_rd_en = 1'b1;
                w_next    = ST_WAIT_RD;
            end
            ST_WAIT_RD:  w_next = ST_OFFER;
            ST_OFFER: begin
                w_valid = 1'b1;
                if (w_ready) w_next = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                result_ready = 1'b1;
                if (result_valid)  w_next = ST_WRITE;
                else if (w_to_hit) w_next = ST_DONE;
            end
            ST_WRITE: begin
                mem_wr_en = 1'b1;
                w_next    = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                done_error   = r_err;
                done_timeout = r_to;
                w_next       = w_start ? ST_READ : ST_IDLE;
            end
            default:     w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cur_layer <= '0;
            r_w         <= '0;
            r_wr_data   <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_to        <= 1'b0;
        end else begin
            if (w_start) r_cur_layer <= w_start_layer;
            if (r_state == ST_WAIT_RD) r_w <= mem_rd_data;

            if (r_state == ST_OFFER && w_ready)
                r_cnt <= '0;
            else if (r_state == ST_WAIT_RES && !result_valid)
                r_cnt <= r_cnt + 1'b1;

            if (r_state == ST_WAIT_RES && result_valid) begin
                r_wr_data <= result;
                r_err     <= upd_error;
            end else if (r_state == ST_WAIT_RES && w_to_hit) begin
                r_to <= 1'b1;
            end

            if (r_state == ST_DONE) begin
                r_err <= 1'b0;
                r_to  <= 1'b0;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign mem_rd_addr = mem_rd_en ? r_cur_layer : '0;
    assign mem_wr_addr = mem_wr_en ? r_cur_layer : '0;
    assign mem_wr_data = r_wr_data;
    assign w           = r_w;

endmodule

// File: tb/tb_weight_update_scheduler.sv
// Directed bench for weight_update_scheduler with a behavioural 1-cycle-latency weight memory.
module tb_weight_update_scheduler;

    localparam int N  = 5;
    localparam int CWD = 16;
    localparam int AW = 2;
    localparam int MW = N * N * CWD;

    localparam logic [MW-1:0] M05 = {25{16'h0005}};
    localparam logic [MW-1:0] M07 = {25{16'h0007}};
    localparam logic [MW-1:0] M10 = {25{16'h0010}};
    localparam logic [MW-1:0] M11 = {25{16'h0011}};
    localparam logic [MW-1:0] M33 = {25{16'h0033}};
    localparam logic [MW-1:0] M44 = {25{16'h0044}};
    localparam logic [MW-1:0] M99 = {25{16'h0099}};
    localparam logic [MW-1:0] MAA = {25{16'h00AA}};

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] req_layer;
    logic          req_valid;
    logic          req_ready;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [MW-1:0] mem_rd_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [MW-1:0] mem_wr_data;
    logic [MW-1:0] w;
    logic          w_valid;
    logic          w_ready;
    logic [MW-1:0] result;
    logic          result_valid;
    logic          result_ready;
    logic          upd_error;
    logic          busy;
    logic          done;
    logic          done_error;
    logic          done_timeout;

    logic [MW-1:0] mem [4] = '{M10, M11, M05, M33};
    int            rd_count = 0;
    int            wr_count = 0;
    int            n_checks = 0;
    int            n_err    = 0;
    int            rd_base;
    int            wr_base;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            rd_count    <= rd_count + 1;
        end
        if (mem_wr_en) begin
            mem[mem_wr_addr] <= mem_wr_data;
            wr_count         <= wr_count + 1;
        end
    end

    weight_update_scheduler #(
        .NEURON_NUM        (N),
        .WEIGHT_CELL_WIDTH (CWD),
        .LAYER_ADDR_WIDTH  (AW),
        .TIMEOUT_CYCLES    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_layer    (req_layer),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .w            (w),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .upd_error    (upd_error),
        .busy         (busy),
        .done         (done),
        .done_error   (done_error),
        .done_timeout (done_timeout)
    );

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_layer = '0; req_valid = 1'b0; w_ready = 1'b0;
        result = '0; result_valid = 1'b0; upd_error = 1'b0;
        mem_rd_data = '0;
        #1;
        check("rst_req_ready", MW'(req_ready), MW'(1));
        check("rst_busy", MW'(busy), MW'(0));
        check("rst_rd_en", MW'(mem_rd_en), MW'(0));
        check("rst_wr_en", MW'(mem_wr_en), MW'(0));
        check("rst_w", w, '0);
        check("rst_wr_data", mem_wr_data, '0);
        check("rst_w_valid", MW'(w_valid), MW'(0));
        check("rst_res_ready", MW'(result_ready), MW'(0));
        check("rst_done", MW'({done, done_error, done_timeout}), MW'(0));
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // ---- single update, layer 2 ----
        req_layer = 2; req_valid = 1'b1;
        check("t1_req_ready", MW'(req_ready), MW'(1));
        tick(); req_valid = 1'b0;                       // c1
        check("t1_rd_en", MW'(mem_rd_en), MW'(1));
        check("t1_rd_addr", MW'(mem_rd_addr), MW'(2));
        check("t1_busy", MW'(busy), MW'(1));
        tick();                                         // c2
        check("t1_wvalid_c2", MW'(w_valid), MW'(0));
        tick();                                         // c3
        check("t1_wvalid_c3", MW'(w_valid), MW'(1));
        check("t1_w", w, M05);
        w_ready = 1'b1;
        tick(); w_ready = 1'b0;                         // c4
        check("t1_res_ready", MW'(result_ready), MW'(1));
        check("t1_wvalid_c4", MW'(w_valid), MW'(0));
        tick(); tick();                                 // c6
        result = M07; result_valid = 1'b1;
        tick(); result_valid = 1'b0;                    // c7
        check("t1_wr_en", MW'(mem_wr_en), MW'(1));
        check("t1_wr_addr", MW'(mem_wr_addr), MW'(2));
        check("t1_wr_data", mem_wr_data, M07);
        check("t1_done_c7", MW'(done), MW'(0));
        tick();                                         // c8
        check("t1_done", MW'(done), MW'(1));
        check("t1_done_err", MW'(done_error), MW'(0));
        check("t1_done_to", MW'(done_timeout), MW'(0));
        check("t1_mem2", mem[2], M07);
        tick();
        check("t1_idle", MW'(busy), MW'(0));

        // ---- backpressure then upd_error, layer 3 ----
        rd_base = rd_count;
        req_layer = 3; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); tick();                                 // c3 OFFER
        for (int i = 0; i < 10; i++) begin
            check("t2_wvalid_hold", MW'(w_valid), MW'(1));
            check("t2_w_stable", w, M33);
            tick();
        end
        check("t2_single_read", MW'(rd_count), MW'(rd_base + 1));
        check("t2_wvalid_c13", MW'(w_valid), MW'(1));
        w_ready = 1'b1;
        tick(); w_ready = 1'b0;
        result = M44; result_valid = 1'b1; upd_error = 1'b1;
        check("t2_res_ready", MW'(result_ready), MW'(1));
        tick(); result_valid = 1'b0; upd_error = 1'b0;
        check("t2_wr_en", MW'(mem_wr_en), MW'(1));
        check("t2_wr_addr", MW'(mem_wr_addr), MW'(3));
        check("t2_wr_data", mem_wr_data, M44);
        tick();
        check("t2_done", MW'(done), MW'(1));
        check("t2_done_err", MW'(done_error), MW'(1));
        check("t2_done_to", MW'(done_timeout), MW'(0));
        tick();
        check("t2_idle", MW'(busy), MW'(0));

        // ---- back-to-back: layer 0, 1 into slot, 3 held off ----
        result = M99;
        req_layer = 0; req_valid = 1'b1;
        tick();                                         // c1 READ 0
        req_layer = 1;
        check("t3_rd_addr0", MW'(mem_rd_addr), MW'(0));
        check("t3_slot_accept", MW'(req_ready), MW'(1));
        tick();                                         // c2
        req_layer = 3;
        check("t3_slot_full", MW'(req_ready), MW'(0));
        tick();                                         // c3 OFFER
        w_ready = 1'b1; result_valid = 1'b1;
        check("t3_offer_no_res", MW'(result_ready), MW'(0));
        check("t3_w0", w, M10);
        check("t3_held_off", MW'(req_ready), MW'(0));
        tick();                                         // c4 WAIT_RES
        check("t3_res_ready", MW'(result_ready), MW'(1));
        tick();                                         // c5 WRITE
        check("t3_wr_addr0", MW'({mem_wr_en, mem_wr_addr}), MW'({1'b1, 2'd0}));
        check("t3_wr_data0", mem_wr_data, M99);
        tick();                                         // c6 DONE
        check("t3_done0", MW'({done, done_error}), MW'({1'b1, 1'b0}));
        check("t3_ready_done", MW'(req_ready), MW'(0));
        tick();                                         // c7 READ 1
        check("t3_rd_addr1", MW'({mem_rd_en, mem_rd_addr}), MW'({1'b1, 2'd1}));
        check("t3_third_accept", MW'(req_ready), MW'(1));
        tick(); req_valid = 1'b0;                       // c8
        check("t3_slot3", MW'(req_ready), MW'(0));
        tick();                                         // c9 OFFER
        check("t3_w1", w, M11);
        result = MAA;
        tick(); tick();                                 // c11 WRITE
        check("t3_wr_addr1", MW'({mem_wr_en, mem_wr_addr}), MW'({1'b1, 2'd1}));
        check("t3_wr_data1", mem_wr_data, MAA);
        tick();                                         // c12 DONE
        check("t3_done1", MW'(done), MW'(1));
        tick();                                         // c13 READ 3
        check("t3_rd_addr3", MW'({mem_rd_en, mem_rd_addr}), MW'({1'b1, 2'd3}));
        tick(); tick();                                 // c15 OFFER
        check("t3_w3_writeback", w, M44);
        tick(); tick();                                 // c17 WRITE
        check("t3_wr_addr3", MW'({mem_wr_en, mem_wr_addr}), MW'({1'b1, 2'd3}));
        tick();                                         // c18 DONE
        check("t3_done3", MW'(done), MW'(1));
        tick();
        w_ready = 1'b0; result_valid = 1'b0;
        check("t3_idle", MW'(busy), MW'(0));

        // ---- timeout, layer 1 ----
        wr_base = wr_count;
        req_layer = 1; req_valid = 1'b1;
        tick(); req_valid = 1'b0;
        tick(); tick();                                 // c3 OFFER
        w_ready = 1'b1;
        tick(); w_ready = 1'b0;                         // c4 WAIT_RES entry
        for (int i = 0; i < 8; i++) begin
            check("t4_no_done", MW'(done), MW'(0));
            check("t4_waiting", MW'(result_ready), MW'(1));
            tick();
        end
        check("t4_done", MW'(done), MW'(1));
        check("t4_done_to", MW'(done_timeout), MW'(1));
        check("t4_done_err", MW'(done_error), MW'(0));
        check("t4_no_write", MW'(wr_count), MW'(wr_base));
        tick();
        check("t4_idle", MW'({busy, done}), MW'(0));

        // ---- reset in WAIT_RES with a pending request ----
        wr_base = wr_count;
        req_layer = 2; req_valid = 1'b1;
        tick();
        req_layer = 0;
        tick(); req_valid = 1'b0;
        check("t5_slot_full", MW'(req_ready), MW'(0));
        tick();                                         // c3 OFFER
        w_ready = 1'b1;
        tick(); w_ready = 1'b0;
        tick();                                         // c5 WAIT_RES
        check("t5_in_wait", MW'(result_ready), MW'(1));
        #2 rst = 1'b1;
        #1;
        check("t5_busy", MW'(busy), MW'(0));
        check("t5_res_ready", MW'(result_ready), MW'(0));
        check("t5_req_ready", MW'(req_ready), MW'(1));
        check("t5_w", w, '0);
        check("t5_wr_data", mem_wr_data, '0);
        check("t5_outs", MW'({w_valid, mem_rd_en, mem_wr_en, done}), MW'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        tick(); tick();
        check("t5_slot_empty", MW'({busy, mem_rd_en}), MW'(0));
        check("t5_no_write", MW'(wr_count), MW'(wr_base));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/weight_update_scheduler.md
Name: weight_update_scheduler

Overview:
Sequences one weight-matrix update per layer around the weight updater datapath (tensor product, learning-rate shift, vector add). It accepts layer-update requests and reads that layer's weight matrix from a layer-indexed weight memory. It offers the matrix on the updater's w handshake, takes the updated matrix from the updater's result handshake, and writes it back to the same address. The updater's a/delta inputs are fed elsewhere; this block owns only the w/result side and the memory port.

Parameters:
NEURON_NUM, 5, neurons per layer; matrix holds NEURON_NUM*NEURON_NUM cells
WEIGHT_CELL_WIDTH, 16, width of one weight cell
LAYER_ADDR_WIDTH, 2, layer index width; memory depth 2**LAYER_ADDR_WIDTH
TIMEOUT_CYCLES, 1024, max cycles spent in WAIT_RES; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_layer  in  LAYER_ADDR_WIDTH  layer whose weights are updated
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid&req_ready
mem_rd_en  out  1  weight memory read strobe
mem_rd_addr  out  LAYER_ADDR_WIDTH  read address
mem_rd_data  in  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
mem_wr_en  out  1  write strobe
mem_wr_addr  out  LAYER_ADDR_WIDTH  write address
mem_wr_data  out  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  write data
w  out  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  weights to updater
w_valid  out  1  w valid
w_ready  in  1  updater accepts w
result  in  NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH  updated weights from updater
result_valid  in  1  result valid
result_ready  out  1  block accepts result
upd_error  in  1  updater overflow flag, sampled on the result handshake
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when an update completes or aborts
done_error  out  1  valid with done: upd_error seen on this update
done_timeout  out  1  valid with done: this update aborted by timeout

Behaviour:
- Reset (async, rst=1): state=IDLE, pending slot empty, timeout counter=0. All outputs 0 except req_ready=1. w and mem_wr_data registers are cleared to 0. A reset mid-update abandons the update with no write.
- Pending slot: one-deep register. req_ready = !pending_valid. An accepted request in IDLE with the slot empty goes straight to READ; otherwise it is stored in the slot.
- FSM states:
  - IDLE: if a request is accepted or the slot is full, go to READ and latch cur_layer. The slot drains first; a new request accepted in the same cycle fills the slot.
  - READ (1 cycle): mem_rd_en=1, mem_rd_addr=cur_layer. Go to WAIT_RD.
  - WAIT_RD (1 cycle): register mem_rd_data into w. Go to OFFER.
  - OFFER: w_valid=1, w held stable. On w_ready go to WAIT_RES; clear the timeout counter.
  - WAIT_RES: result_ready=1. On result_valid, register result into mem_wr_data, latch err=upd_error, go to WRITE. The counter increments otherwise. Reaching TIMEOUT_CYCLES (nonzero) sets to=1 and goes to DONE with no write.
  - WRITE (1 cycle): mem_wr_en=1, mem_wr_addr=cur_layer. Go to DONE.
  - DONE (1 cycle): done=1, done_error=err, done_timeout=to. If the slot is full or a request is accepted this cycle, go to READ; else go to IDLE. Clear err and to.
- Latency, request accepted in IDLE at cycle 0:
  - mem_rd_en at cycle 1; w_valid from cycle 3.
  - With w_ready at cycle 3 and result_valid at cycle k>3: mem_wr_en at k+1, done at k+2.
- Data is passed unmodified; no arithmetic in this block. Width of w, result and memory words = NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH.
- A result_valid arriving outside WAIT_RES is not accepted (result_ready=0).
- Simultaneous w_ready and result_valid in OFFER: only the w handshake is taken; the result is taken the next cycle.
- A read and a write to the same layer never overlap, because updates are strictly serialised.

Decomposition:
- Shared package: FSM state encoding (IDLE, READ, WAIT_RD, OFFER, WAIT_RES, WRITE, DONE), matrix-width localparam MATRIX_WIDTH = NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH, timeout counter width derived via clog2(TIMEOUT_CYCLES+1).
- One natural sub-module: request_skid (the one-deep pending request slot with valid/ready).

Test Plan:
- Single update: memory[2] = matrix of all 0x0005; req_layer=2 at cycle 0; w_ready at cycle 3; result = all 0x0007 at cycle 6 -> mem_rd_en at cycle 1, mem_wr_en at cycle 7 writing all 0x0007 to address 2, done at cycle 8 with done_error=0.
- Back-to-back: requests for layer 0 then layer 1 while busy -> second accepted into the slot, req_ready=0. A third request is held off until DONE. Layer 1 READ occurs the cycle after the first done.
- Backpressure: w_ready low for 10 cycles -> w_valid held, w stable for all 10 cycles, no memory read repeated.
- Error: upd_error=1 on the result handshake -> write still occurs, done_error=1 on done, cleared for the next update.
- Timeout: TIMEOUT_CYCLES=8, result_valid never asserted -> no mem_wr_en, done=1 with done_timeout=1 exactly 8 cycles after entering WAIT_RES, return to IDLE.
- Reset mid-update: rst pulse while in WAIT_RES -> all outputs 0 asynchronously, req_ready=1, slot empty, no write observed.
